// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue block: widths, op codes, FSM state
// and the latched instruction record. Optional feature macro: ALU_ISSUE_IMM_EN.
package alu_pkg;
  localparam int RW   = 6;
  localparam int DW   = 32;
  localparam int NREG = 1 << RW;

  localparam logic [3:0] OP_OR  = 4'd0;
  localparam logic [3:0] OP_XOR = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs0;
    logic [RW-1:0] rs1;
`ifdef ALU_ISSUE_IMM_EN
    logic          imm_sel;
    logic [DW-1:0] imm;
`endif
  } instr_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_OR) || (op == OP_XOR) || (op == OP_AND) ||
           (op == OP_ADD) || (op == OP_SUB);
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// 64 x 32 register file: two async read ports, one debug read port,
// one synchronous write port, synchronous clear of every entry.
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [RW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [RW-1:0] ra0,
  input  logic [RW-1:0] ra1,
  input  logic [RW-1:0] dbg_a,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] dbg_d
);
  logic [NREG-1:0][DW-1:0] mem;

  // clear wins over a write in the same edge, so an aborted WRITE leaves no trace
  always_ff @(posedge clk) begin
    if (reset)   mem     <= '0;
    else if (we) mem[wa] <= wd;
  end

  assign rd0   = mem[ra0];
  assign rd1   = mem[ra1];
  assign dbg_d = mem[dbg_a];
endmodule

// File: rtl/alu_issue.sv
// Single-issue ALU sequencer: IDLE -> READ -> EXEC -> WRITE around an
// external combinational ALU. Define ALU_ISSUE_IMM_EN to add an immediate
// second operand.
module alu_issue
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [RW-1:0] instr_rd,
  input  logic [RW-1:0] instr_rs0,
  input  logic [RW-1:0] instr_rs1,
`ifdef ALU_ISSUE_IMM_EN
  input  logic          instr_imm_sel,
  input  logic [DW-1:0] instr_imm,
`endif
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_d0,
  output logic [DW-1:0] alu_d1,
  input  logic [DW-1:0] alu_dout,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          err_illegal,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  state_t        st, nxt;
  instr_t        ins, inc;
  logic [DW-1:0] result, rf_d0, rf_d1, d1_src;

  alu_regfile u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (st == WRITE),
    .wa    (ins.rd),
    .wd    (result),
    .ra0   (ins.rs0),
    .ra1   (ins.rs1),
    .dbg_a (dbg_addr),
    .rd0   (rf_d0),
    .rd1   (rf_d1),
    .dbg_d (dbg_data)
  );

  // gather the offered instruction into one record
  always_comb begin
    inc     = '0;
    inc.op  = instr_op;
    inc.rd  = instr_rd;
    inc.rs0 = instr_rs0;
    inc.rs1 = instr_rs1;
`ifdef ALU_ISSUE_IMM_EN
    inc.imm_sel = instr_imm_sel;
    inc.imm     = instr_imm;
`endif
  end

`ifdef ALU_ISSUE_IMM_EN
  assign d1_src = ins.imm_sel ? ins.imm : rf_d1;
`else
  assign d1_src = rf_d1;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= nxt;
  end

  // next state; illegal ops bail out of READ without touching the ALU
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:  if (instr_valid) nxt = READ;
      READ:  nxt = op_legal(ins.op) ? EXEC : IDLE;
      EXEC:  nxt = WRITE;
      WRITE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // datapath: latch on handshake, operand regs in READ, result in EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      ins         <= '0;
      alu_op      <= '0;
      alu_d0      <= '0;
      alu_d1      <= '0;
      result      <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (st == IDLE && instr_valid) ins <= inc;
      if (st == READ) begin
        if (op_legal(ins.op)) begin
          alu_op <= ins.op;
          alu_d0 <= rf_d0;
          alu_d1 <= d1_src;
        end else begin
          err_illegal <= 1'b1;
        end
      end
      if (st == EXEC) result <= alu_dout;
    end
  end

  assign instr_ready = (st == IDLE);
  assign wb_valid    = (st == WRITE);
  assign wb_rd       = ins.rd;
  assign wb_data     = result;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue. The bench plays the external ALU; a seed
// mode lets it return a chosen value so registers can be loaded from reset.
module tb_alu_issue;
  import alu_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid, instr_ready;
  logic [3:0]    instr_op;
  logic [5:0]    instr_rd, instr_rs0, instr_rs1;
  logic          instr_imm_sel;
  logic [31:0]   instr_imm;
  logic [3:0]    alu_op;
  logic [31:0]   alu_d0, alu_d1, alu_dout;
  logic          wb_valid;
  logic [5:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          err_illegal;
  logic [5:0]    dbg_addr;
  logic [31:0]   dbg_data;

  logic          seed_en;
  logic [31:0]   seed_val;

  alu_issue dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd),
    .instr_rs0(instr_rs0), .instr_rs1(instr_rs1),
`ifdef ALU_ISSUE_IMM_EN
    .instr_imm_sel(instr_imm_sel), .instr_imm(instr_imm),
`endif
    .alu_op(alu_op), .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_dout(alu_dout),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_illegal(err_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] op_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a | b;
      4'd1: return a ^ b;
      4'd2: return a & b;
      4'd4: return a + b;
      4'd5: return a - b;
      default: return 32'h0;
    endcase
  endfunction

  // external ALU
  always_comb alu_dout = seed_en ? seed_val : op_fn(alu_op, alu_d0, alu_d1);

  // reference state
  logic [31:0] model_r [64];
  bit          exp_err;

  typedef struct { logic [5:0] rd; logic [31:0] data; int due; } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every writeback must match the oldest expectation, on time
  always @(negedge clk) begin
    if (reset === 1'b0 && wb_valid !== 1'b0) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected act rd=%0d data=%h exp none", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_rd", {26'd0, wb_rd}, {26'd0, e.rd});
        chk("wb_data", wb_data, e.data);
        chk("wb_latency", cyc, e.due);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [5:0] rd, input logic [5:0] rs0,
                       input logic [5:0] rs1, input bit seed, input logic [31:0] sv,
                       input bit isel, input logic [31:0] imm, input bit push, output int hs);
    int n;
    logic [31:0] res;
    n = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL ready_timeout act=0 exp=1"); end
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs0 = rs0; instr_rs1 = rs1;
    instr_imm_sel = isel; instr_imm = imm;
    seed_en = seed; seed_val = sv;
    @(posedge clk); #1;
    hs = cyc;
    // scramble inputs: they must be ignored outside the handshake
    instr_valid = 1'b0; instr_op = 4'($urandom); instr_rd = 6'($urandom);
    instr_rs0 = 6'($urandom); instr_rs1 = 6'($urandom); instr_imm = $urandom;
    instr_imm_sel = 1'($urandom);
    if (op == 0 || op == 1 || op == 2 || op == 4 || op == 5) begin
      res = seed ? sv : op_fn(op, model_r[rs0], isel ? imm : model_r[rs1]);
      if (push) begin
        q.push_back('{rd: rd, data: res, due: hs + 2});
        model_r[rd] = res;
      end
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic dbg_chk(input string nm, input logic [5:0] a, input logic [31:0] exp);
    dbg_addr = a; #1;
    chk(nm, dbg_data, exp);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (q.size() != 0) begin checks++; errors++; $display("FAIL drain_timeout act=%0d exp=0", q.size()); q.delete(); end
    repeat (2) @(negedge clk);
  endtask

  task automatic load(input logic [5:0] rd, input logic [31:0] v);
    int hs;
    issue(4'd4, rd, 6'd0, 6'd0, 1'b1, v, 1'b0, 32'h0, 1'b1, hs);
  endtask

  int hs;

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs0 = '0;
    instr_rs1 = '0; instr_imm_sel = 1'b0; instr_imm = '0; dbg_addr = '0;
    seed_en = 1'b0; seed_val = '0; exp_err = 1'b0;
    foreach (model_r[i]) model_r[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    chk("rst_alu_d0", alu_d0, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    dbg_chk("rst_dbg63", 6'd63, 32'd0);

    // ADD 3 + 7, with operand-register and latency observation
    load(6'd1, 32'd3);
    load(6'd2, 32'd7);
    issue(4'd4, 6'd3, 6'd1, 6'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, hs);
    @(negedge clk);
    chk("read_ready_low", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("exec_alu_op", {28'd0, alu_op}, 32'd4);
    chk("exec_alu_d0", alu_d0, 32'd3);
    chk("exec_alu_d1", alu_d1, 32'd7);
    @(negedge clk);
    @(negedge clk);
    dbg_chk("dbg_after_write", 6'd3, 32'd10);
    drain();

    // wraparound
    load(6'd1, 32'hFFFF_FFFF);
    load(6'd2, 32'd1);
    issue(4'd4, 6'd4, 6'd1, 6'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, hs);
    issue(4'd5, 6'd5, 6'd2, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, hs);
    drain();
    dbg_chk("add_wrap", 6'd4, 32'd0);
    dbg_chk("sub_wrap", 6'd5, 32'd2);

    // self-dependent, back-to-back
    load(6'd1, 32'd5);
    issue(4'd4, 6'd1, 6'd1, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, hs);
    issue(4'd4, 6'd1, 6'd1, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, hs);
    drain();
    dbg_chk("dep_chain", 6'd1, 32'd20);

`ifdef ALU_ISSUE_IMM_EN
    load(6'd1, 32'hF0);
    issue(4'd0, 6'd6, 6'd1, 6'd2, 1'b0, 32'h0, 1'b1, 32'h0F, 1'b1, hs);
    drain();
    dbg_chk("imm_or", 6'd6, 32'hFF);
`endif

    // illegal op
    issue(4'd6, 6'd7, 6'd1, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, hs);
    @(negedge clk);
    chk("illegal_read_busy", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("illegal_ready_back", {31'd0, instr_ready}, 32'd1);
    chk("illegal_err_set", {31'd0, err_illegal}, 32'd1);
    repeat (4) @(negedge clk);
    chk("illegal_err_sticky", {31'd0, err_illegal}, 32'd1);
    dbg_chk("illegal_no_write", 6'd7, model_r[7]);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      int sel;
      sel = $urandom_range(0, 19);
      case (sel % 5)
        0: op = 4'd0; 1: op = 4'd1; 2: op = 4'd2; 3: op = 4'd4; default: op = 4'd5;
      endcase
      if (sel == 19) op = 4'd3 + 4'($urandom_range(0, 1) * 5);
      issue(op, 6'($urandom), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), $urandom,
            1'b0, 32'h0, 1'b1, hs);
    end
    drain();
    chk("rand_err", {31'd0, err_illegal}, {31'd0, exp_err});
    for (int a = 0; a < 64; a++) dbg_chk("rand_regfile", 6'(a), model_r[a]);

    // reset while in EXEC aborts the instruction
    issue(4'd4, 6'd9, 6'd1, 6'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, hs);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    foreach (model_r[i]) model_r[i] = '0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_err", {31'd0, err_illegal}, 32'd0);
    chk("abort_wb_rd", {26'd0, wb_rd}, 32'd0);
    repeat (4) @(negedge clk);
    for (int a = 0; a < 64; a++) dbg_chk("abort_regfile", 6'(a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
